// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES ripple segments of CHUNK bits, one register
// stage per segment, with valid/ready flow control and per-stage backpressure.
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    // Stage k register holds a beat whose sum chunks 0..k are complete.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];

    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];

    // Stage 0 is fed by the input port with b already inverted for subtraction.
    always_comb begin : p_src
        src_v[0] = in_valid_i;
        src_a[0] = a_i;
        src_b[0] = sub_i ? ~b_i : b_i;
        src_s[0] = '0;
        src_c[0] = sub_i | cin_i;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
    end

    // A stage loads when empty or when its beat moves on this cycle.
    always_comb begin : p_ready
        logic adv;
        adv = out_ready_i;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            ld[k] = ~v_q[k] | adv;
            adv   = ld[k];
        end
    end

    always_comb begin : p_next
        logic [CHUNK:0] part;
        for (int k = 0; k < int'(STAGES); k++) begin
            v_d[k] = ld[k] ? src_v[k] : v_q[k];
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
            c_d[k] = c_q[k];
            part   = {1'b0, src_a[k][k*CHUNK +: CHUNK]} + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, src_c[k]};
            if (ld[k] && src_v[k]) begin
                a_d[k]                   = src_a[k];
                b_d[k]                   = src_b[k];
                s_d[k]                   = src_s[k];
                s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
                c_d[k]                   = part[CHUNK];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign in_ready_o  = ld[0];
    assign out_valid_o = v_q[LAST];
    assign sum_o       = s_q[LAST];
    assign cout_o      = c_q[LAST];
    // b_q holds the effective (possibly inverted) operand, so this covers add and subtract.
    assign ovf_o       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                       & (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
